// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared PIPO
// register through a LOAD / ACK four-phase handshake.
module pipo_load_arbiter #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   wdata,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         ack,
  output logic                 pipo_load,
  output logic [WIDTH-1:0]     pipo_d,
  output logic                 busy,
  output logic [2:0]           last_id
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    pick;
  logic [N-1:0]     pick_oh;
  logic [WIDTH-1:0] pick_data;
  logic             found;

  // Search starts one past the last winner and wraps; first requester found wins.
  always_comb begin
    int unsigned idx;
    pick      = '0;
    pick_oh   = '0;
    pick_data = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(last_id) + 1 + off) % N;
      if (!found && req[idx[IW-1:0]]) begin
        found               = 1'b1;
        pick                = idx[IW-1:0];
        pick_oh[idx[IW-1:0]] = 1'b1;
        pick_data           = wdata[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb busy = (state != IDLE);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      winner    <= '0;
      gnt       <= '0;
      ack       <= '0;
      pipo_load <= 1'b0;
      pipo_d    <= '0;
      last_id   <= 3'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= LOAD;
            winner    <= pick;
            gnt       <= pick_oh;
            pipo_d    <= pick_data;
            pipo_load <= 1'b1;
          end
        end
        LOAD: begin
          state     <= ACK;
          ack       <= gnt;
          last_id   <= 3'(winner);
          pipo_load <= 1'b0;
        end
        ACK: begin
          // Release only once the winner withdraws its request.
          if (!req[winner]) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          ack       <= '0;
          pipo_load <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipo_load_arbiter.md
PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001: Parameter WIDTH, default 4, SHALL set the bit width of each write data lane and of the PIPO data bus.
REQ-002: Parameter N, default 4, SHALL set the number of requesters; N is an integer in the range 2..8.
REQ-003: clk  input  1  SHALL be the single clock; all state changes SHALL occur on its rising edge.
REQ-004: clear  input  1  SHALL be the asynchronous, active-low reset.
REQ-005: req  input  N  SHALL carry one write request per requester; bit i belongs to requester i.
REQ-006: wdata  input  N*WIDTH  SHALL carry requester write data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007: gnt  output  N  SHALL be the registered one-hot grant, or all zeros when no requester is granted.
REQ-008: ack  output  N  SHALL be the registered one-hot completion acknowledge.
REQ-009: pipo_load  output  1  SHALL be the load strobe to the shared PIPO register.
REQ-010: pipo_d  output  WIDTH  SHALL be the registered data presented to the shared PIPO register.
REQ-011: busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012: last_id  output  3  SHALL hold the index of the most recently granted requester.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, LOAD and ACK.
REQ-014: In IDLE with req != 0, the next edge SHALL select the winner by round-robin, set gnt to the winner's one-hot, capture that requester's wdata lane into pipo_d, and enter LOAD.
REQ-015: Round-robin search SHALL start at index (last_id+1) mod N and wrap from N-1 to 0.
REQ-016: After clear, requester 0 SHALL have highest priority; the pointer SHALL start so that index 0 is searched first.
REQ-017: In LOAD, pipo_load SHALL be 1 for exactly one cycle, with pipo_d stable and gnt held.
REQ-018: The next edge after LOAD SHALL enter ACK, set ack to the winner's one-hot, and update last_id to the winner.
REQ-019: gnt SHALL remain asserted throughout ACK.
REQ-020: In ACK, the FSM SHALL remain in ACK while req[winner]=1.
REQ-021: The first edge in ACK with req[winner]=0 SHALL clear gnt and ack and return the FSM to IDLE (four-phase handshake).
REQ-022: Grant-to-load latency SHALL be 1 cycle from the arbitration edge; minimum transaction length SHALL be 3 cycles (LOAD, ACK, IDLE).
REQ-023: If the winner drops req during LOAD, the load SHALL still complete, ACK SHALL last exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-024: Changes to req or wdata from non-winners while busy=1 SHALL be ignored.
REQ-025: A pending request SHALL be arbitrated only in IDLE; there SHALL be no back-to-back grant without an intervening IDLE cycle.
REQ-026: pipo_d SHALL hold its last loaded value when not in LOAD; pipo_load SHALL be 0 outside LOAD.
REQ-027: For any fixed set of continuously asserted requests, every requester SHALL be granted within N transactions (starvation-free).

Reset
REQ-028: clear=0 SHALL immediately, without waiting for a clock edge, force the state to IDLE and set gnt=0, ack=0, pipo_load=0, pipo_d=0, busy=0 and last_id=N-1.
REQ-029: clear asserted mid-transaction SHALL abort that transaction with no further pipo_load pulse.
REQ-030: On clear deassertion, the first clk edge SHALL arbitrate normally.

Verification
REQ-031: Apply reset, then set req=0001 with lane0=0011 -> gnt=0001; pipo_load high for one cycle with pipo_d=0011; ack=0001 next cycle; after req drops, IDLE; last_id=0.
REQ-032: Hold req=1111 with lanes 0..3 = 0111, 1011, 1001, 1111, each requester dropping req on its ack -> grants in order 0,1,2,3 and pipo_d in order 0111, 1011, 1001, 1111.
REQ-033: With last_id=3, set req=1001 -> requester 0 is granted (wrap-around); then hold req=1000 -> requester 3 is granted next.
REQ-034: Winner keeps req high for 5 cycles in ACK -> ack and gnt held 5 cycles; a single pipo_load pulse; busy=1 throughout.
REQ-035: Assert clear=0 during LOAD -> pipo_load, gnt, ack, pipo_d and busy are 0 before the next edge; after release, req=0100 -> requester 2 is granted.
REQ-036: Winner drops req during LOAD -> load completes with ack for one cycle, then IDLE; a competing req=0010 is granted only after that IDLE cycle.
